// File: rtl/trivium_pkg.sv
// Shared constants and types for the Trivium keystream core.
// State bit s[n] of the algorithm lives at register bit n-1.
package trivium_pkg;

    localparam int KEY_W           = 80;
    localparam int IV_W            = 80;
    localparam int STATE_W         = 288;
    localparam int INIT_ROUNDS_DEF = 1152;

    localparam int TAP_66  = 66;
    localparam int TAP_69  = 69;
    localparam int TAP_91  = 91;
    localparam int TAP_92  = 92;
    localparam int TAP_93  = 93;
    localparam int TAP_162 = 162;
    localparam int TAP_171 = 171;
    localparam int TAP_175 = 175;
    localparam int TAP_176 = 176;
    localparam int TAP_177 = 177;
    localparam int TAP_243 = 243;
    localparam int TAP_264 = 264;
    localparam int TAP_286 = 286;
    localparam int TAP_287 = 287;
    localparam int TAP_288 = 288;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } trivium_state_t;

    typedef logic [STATE_W-1:0] trivium_reg_t;

    // Key in s1..s80, IV in s94..s173, s286..s288 set, everything else clear.
    function automatic trivium_reg_t load_state(input logic [KEY_W-1:0] key,
                                                input logic [IV_W-1:0]  iv);
        trivium_reg_t s;
        s              = '0;
        s[0 +: KEY_W]  = key;
        s[93 +: IV_W]  = iv;
        s[285 +: 3]    = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: next state plus the keystream bit z.
module trivium_round
    import trivium_pkg::*;
(
    input  trivium_reg_t s_i,
    output trivium_reg_t s_o,
    output logic         z_o
);

    logic t1, t2, t3;
    logic t1_fb, t2_fb, t3_fb;

    assign t1 = s_i[TAP_66-1]  ^ s_i[TAP_93-1];
    assign t2 = s_i[TAP_162-1] ^ s_i[TAP_177-1];
    assign t3 = s_i[TAP_243-1] ^ s_i[TAP_288-1];

    // z uses the linear taps only; the AND terms feed back into the shift.
    assign z_o = t1 ^ t2 ^ t3;

    assign t1_fb = t1 ^ (s_i[TAP_91-1]  & s_i[TAP_92-1])  ^ s_i[TAP_171-1];
    assign t2_fb = t2 ^ (s_i[TAP_175-1] & s_i[TAP_176-1]) ^ s_i[TAP_264-1];
    assign t3_fb = t3 ^ (s_i[TAP_286-1] & s_i[TAP_287-1]) ^ s_i[TAP_69-1];

    assign s_o = {s_i[286:177], t2_fb, s_i[175:93], t1_fb, s_i[91:0], t3_fb};

endmodule

// File: rtl/trivium_keystream_core.sv
// Trivium engine: key/IV load, warm-up, then OUT_W keystream bits per
// accepted valid/ready transfer.
module trivium_keystream_core
    import trivium_pkg::*;
#(
    parameter int OUT_W       = 1,
    parameter int INIT_ROUNDS = INIT_ROUNDS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    output logic             busy,
    output logic [OUT_W-1:0] ks_o,
    output logic             ks_valid,
    input  logic             ks_ready
);

    localparam int N_STEPS = INIT_ROUNDS / OUT_W;
    localparam int CNT_W   = $clog2(N_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STEPS - 1);

    if (!(OUT_W == 1 || OUT_W == 2 || OUT_W == 4 || OUT_W == 8 ||
          OUT_W == 16 || OUT_W == 32 || OUT_W == 64)) begin : g_bad_out_w
        $error("trivium_keystream_core: OUT_W must be 1, 2, 4, 8, 16, 32 or 64");
    end
    if (INIT_ROUNDS % OUT_W != 0) begin : g_bad_rounds
        $error("trivium_keystream_core: INIT_ROUNDS must be a multiple of OUT_W");
    end

    trivium_reg_t        state_q, state_d;
    trivium_state_t      fsm_q, fsm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    trivium_reg_t        chain [OUT_W+1];
    logic [OUT_W-1:0]    z_word;

    // Round g produces keystream bit g, so ks_o[0] is the earliest bit.
    assign chain[0] = state_q;
    for (genvar g = 0; g < OUT_W; g++) begin : g_round
        trivium_round u_round (
            .s_i (chain[g]),
            .s_o (chain[g+1]),
            .z_o (z_word[g])
        );
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = load_state(key, iv);
            cnt_d   = '0;
            fsm_d   = INIT;
        end else begin
            unique case (fsm_q)
                INIT: begin
                    state_d = chain[OUT_W];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        fsm_d = RUN;
                    end
                end
                RUN: begin
                    if (ks_ready) begin
                        state_d = chain[OUT_W];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the whole 288-bit state is plain flops, not a memory, so resetting it is cheap and keeps outputs deterministic.
        if (!rst) begin
            state_q <= '0;
            fsm_q   <= IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state_q <= state_d;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (fsm_q == INIT);
    assign ks_valid = (fsm_q == RUN);
    assign ks_o     = ks_valid ? z_word : '0;

endmodule

// File: tb/tb_trivium_keystream_core.sv
// Scoreboard bench: three cores (OUT_W = 1, 8, 64) checked against a
// bit-serial Trivium reference model.
module tb_trivium_keystream_core;

    localparam logic [79:0] KA = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] IA = 80'hFEDCBA9876543210FEDC;
    localparam logic [79:0] KB = 80'h80000000000000000001;
    localparam logic [79:0] IB = 80'h00000000000000000000;
    localparam logic [79:0] KC = 80'h3C3C3C3C3C3C3C3C3C3C;
    localparam logic [79:0] IC = 80'h0F1E2D3C4B5A69788796;
    localparam logic [79:0] KD = 80'hFFFFFFFFFFFFFFFFFFFF;
    localparam logic [79:0] ID = 80'h1234500000000000ABCD;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n_v;
    logic [2:0]  start_v;
    logic [2:0]  ready_v;
    logic [2:0]  busy_v;
    logic [2:0]  valid_v;
    logic [79:0] key_v [3];
    logic [79:0] iv_v  [3];
    logic [0:0]  ks1;
    logic [7:0]  ks8;
    logic [63:0] ks64;
    logic [63:0] ks_w  [3];

    assign ks_w[0] = {63'd0, ks1};
    assign ks_w[1] = {56'd0, ks8};
    assign ks_w[2] = ks64;

    trivium_keystream_core #(.OUT_W(1)) u_d1 (
        .clk(clk), .rst(rst_n_v[0]), .start(start_v[0]), .key(key_v[0]), .iv(iv_v[0]),
        .busy(busy_v[0]), .ks_o(ks1), .ks_valid(valid_v[0]), .ks_ready(ready_v[0])
    );
    trivium_keystream_core #(.OUT_W(8)) u_d8 (
        .clk(clk), .rst(rst_n_v[1]), .start(start_v[1]), .key(key_v[1]), .iv(iv_v[1]),
        .busy(busy_v[1]), .ks_o(ks8), .ks_valid(valid_v[1]), .ks_ready(ready_v[1])
    );
    trivium_keystream_core #(.OUT_W(64)) u_d64 (
        .clk(clk), .rst(rst_n_v[2]), .start(start_v[2]), .key(key_v[2]), .iv(iv_v[2]),
        .busy(busy_v[2]), .ks_o(ks64), .ks_valid(valid_v[2]), .ks_ready(ready_v[2])
    );

    int          total = 0;
    int          bad   = 0;
    int          acc_cnt [3] = '{0, 0, 0};
    bit          mon_on = 1'b0;
    bit          hold_v [3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] held   [3];
    bit          ks_bits [$];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_w(input int d);
        case (d)
            0:       return 1;
            1:       return 8;
            default: return 64;
        endcase
    endfunction

    task automatic push_exp(input int d, input logic [63:0] w);
        case (d)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic clear_exp(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    function automatic int exp_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_exp(input int d, output bit ok, output logic [63:0] w);
        ok = (exp_size(d) > 0);
        w  = '0;
        if (ok) begin
            case (d)
                0:       w = q0.pop_front();
                1:       w = q1.pop_front();
                default: w = q2.pop_front();
            endcase
        end
    endtask

    // Bit-serial reference: 1-based state array, warm-up, then nbits of z.
    task automatic model_bits(input logic [79:0] k, input logic [79:0] v, input int nbits);
        bit s [1:288];
        bit t1, t2, t3, z;
        ks_bits.delete();
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + nbits; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i >= 2; i--) s[i] = s[i-1];
            s[1]   = t3;
            s[94]  = t1;
            s[178] = t2;
            if (r >= 1152) ks_bits.push_back(z);
        end
    endtask

    task automatic push_run(input int d, input logic [79:0] k, input logic [79:0] v, input int nw);
        int          w;
        logic [63:0] word;
        w = dut_w(d);
        model_bits(k, v, nw * w);
        for (int n = 0; n < nw; n++) begin
            word = '0;
            for (int j = 0; j < w; j++) word[j] = ks_bits[n * w + j];
            push_exp(d, word);
        end
    endtask

    // Pulse start, scramble key/iv afterwards, and time the warm-up.
    task automatic start_and_warmup(input int d, input logic [79:0] k, input logic [79:0] v);
        int n_exp, i, busy_n;
        n_exp = 1152 / dut_w(d);
        key_v[d]   = k;
        iv_v[d]    = v;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        key_v[d]   = ~k;
        iv_v[d]    = v ^ 80'hA5A5A5A5A5A5A5A5A5A5;
        i      = 0;
        busy_n = 0;
        while (!valid_v[d] && i < n_exp + 20) begin
            if (busy_v[d]) busy_n++;
            @(posedge clk); #1;
            i++;
        end
        check($sformatf("d%0d_warmup_len", d), 64'(i), 64'(n_exp));
        check($sformatf("d%0d_busy_cycles", d), 64'(busy_n), 64'(n_exp));
        check($sformatf("d%0d_busy_low_in_run", d), {63'd0, busy_v[d]}, 64'd0);
    endtask

    task automatic wait_acc(input int d, input int target, input int budget);
        int i;
        i = 0;
        while (acc_cnt[d] < target && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check($sformatf("d%0d_words_accepted", d), 64'(acc_cnt[d]), 64'(target));
    endtask

    task automatic check_idle(input int d, input string tag);
        check($sformatf("d%0d_%s_busy", d, tag),  {63'd0, busy_v[d]},  64'd0);
        check($sformatf("d%0d_%s_valid", d, tag), {63'd0, valid_v[d]}, 64'd0);
        check($sformatf("d%0d_%s_ks", d, tag),    ks_w[d],             64'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    always @(negedge clk) begin
        logic [63:0] w;
        bit          ok;
        for (int d = 0; d < 3; d++) begin
            if (mon_on && !valid_v[d])
                check($sformatf("d%0d_ks_zero_when_invalid", d), ks_w[d], 64'd0);
            if (mon_on && rst_n_v[d] && !start_v[d] && valid_v[d]) begin
                if (hold_v[d])
                    check($sformatf("d%0d_stall_stable", d), ks_w[d], held[d]);
                if (ready_v[d]) begin
                    pop_exp(d, ok, w);
                    check($sformatf("d%0d_word_expected", d), {63'd0, ok}, 64'd1);
                    if (ok) check($sformatf("d%0d_word%0d", d, acc_cnt[d]), ks_w[d], w);
                    acc_cnt[d] = acc_cnt[d] + 1;
                    hold_v[d]  = 1'b0;
                end else begin
                    hold_v[d] = 1'b1;
                    held[d]   = ks_w[d];
                end
            end else begin
                hold_v[d] = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       b;
        bit [3:0] pat;
        pat     = 4'b1001;
        rst_n_v = 3'b000;
        start_v = 3'b111;
        ready_v = 3'b000;
        for (int d = 0; d < 3; d++) begin
            key_v[d] = '0;
            iv_v[d]  = '0;
        end

        // Reset held for three cycles with start asserted.
        repeat (3) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) check_idle(d, "in_reset");
        end
        rst_n_v = 3'b111;
        start_v = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check_idle(d, "after_reset");
        mon_on = 1'b1;

        // All-zero key/IV, bit-serial core, 512 bits.
        ready_v[0] = 1'b1;
        b = acc_cnt[0];
        push_run(0, 80'h0, 80'h0, 512);
        start_and_warmup(0, 80'h0, 80'h0);
        wait_acc(0, b + 512, 700);
        ready_v[0] = 1'b0;

        // Same key/IV on the 1-bit and 64-bit cores.
        push_run(2, KA, IA, 8);
        push_run(0, KA, IA, 512);
        fork
            begin
                int b2;
                b2 = acc_cnt[2];
                ready_v[2] = 1'b1;
                start_and_warmup(2, KA, IA);
                wait_acc(2, b2 + 8, 40);
                ready_v[2] = 1'b0;
            end
            begin
                int b0;
                b0 = acc_cnt[0];
                ready_v[0] = 1'b1;
                start_and_warmup(0, KA, IA);
                wait_acc(0, b0 + 512, 700);
                ready_v[0] = 1'b0;
            end
        join

        // Backpressure on the 8-bit core with a 1-0-0-1 ready pattern.
        b = acc_cnt[1];
        push_run(1, KB, IB, 32);
        ready_v[1] = 1'b1;
        start_and_warmup(1, KB, IB);
        for (int p = 0; p < 300 && acc_cnt[1] < b + 32; p++) begin
            ready_v[1] = pat[p % 4];
            @(posedge clk); #1;
        end
        ready_v[1] = 1'b0;
        check("d1_bp_words_accepted", 64'(acc_cnt[1]), 64'(b + 32));

        // Restart at RUN word 5, then again at INIT cycle 10.
        b = acc_cnt[1];
        push_run(1, KA, IA, 5);
        ready_v[1] = 1'b1;
        start_and_warmup(1, KA, IA);
        wait_acc(1, b + 5, 40);
        check("d1_valid_at_word5", {63'd0, valid_v[1]}, 64'd1);
        clear_exp(1);
        b = acc_cnt[1];
        push_run(1, KC, IC, 4);
        start_and_warmup(1, KC, IC);
        wait_acc(1, b + 4, 40);
        key_v[1]   = KD;
        iv_v[1]    = ID;
        start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        check("d1_busy_after_restart", {63'd0, busy_v[1]}, 64'd1);
        check("d1_valid_after_restart", {63'd0, valid_v[1]}, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        clear_exp(1);
        b = acc_cnt[1];
        push_run(1, KB, IB, 8);
        start_and_warmup(1, KB, IB);
        wait_acc(1, b + 8, 40);
        ready_v[1] = 1'b0;

        // One-cycle reset during INIT.
        key_v[1]   = KD;
        iv_v[1]    = ID;
        start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("d1_busy_before_reset", {63'd0, busy_v[1]}, 64'd1);
        rst_n_v[1] = 1'b0;
        @(posedge clk); #1;
        rst_n_v[1] = 1'b1;
        check_idle(1, "init_reset");
        repeat (5) @(posedge clk);
        #1;
        check_idle(1, "init_reset_later");

        // One-cycle reset during RUN with ks_valid high.
        clear_exp(1);
        b = acc_cnt[1];
        push_run(1, KD, ID, 6);
        ready_v[1] = 1'b1;
        start_and_warmup(1, KD, ID);
        wait_acc(1, b + 2, 40);
        check("d1_valid_before_reset", {63'd0, valid_v[1]}, 64'd1);
        rst_n_v[1] = 1'b0;
        @(posedge clk); #1;
        rst_n_v[1] = 1'b1;
        check_idle(1, "run_reset");
        repeat (5) @(posedge clk);
        #1;
        check_idle(1, "run_reset_later");
        ready_v[1] = 1'b0;
        clear_exp(1);

        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_scoreboard_drained", d), 64'(exp_size(d)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
